// File: rtl/rv32_pkg.sv
// Shared rv32 decode constants, scoreboard entry type and hazard FSM state.
package rv32_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned FCNT_W = 2;

   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } hz_state_t;

   // Saturating increment for the performance counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/hz_decode.sv
// Register-usage decode of an rv32 instruction; shared by hazard and forwarding logic.
module hz_decode
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0]  dec_instr,
   output logic             uses_rs1,
   output logic             uses_rs2,
   output logic             writes_rd,
   output logic [REG_W-1:0] rs1,
   output logic [REG_W-1:0] rs2,
   output logic [REG_W-1:0] rd
);

   logic [OPC_W-1:0] opcode;
   logic             rd_op;
   logic             unused_fields;

   assign opcode        = dec_instr[6:0];
   assign rd            = dec_instr[11:7];
   assign rs1           = dec_instr[19:15];
   assign rs2           = dec_instr[24:20];
   assign unused_fields = ^{dec_instr[31:25], dec_instr[14:12]};

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      rd_op    = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL: rd_op = 1'b1;
         OP_JALR: begin
            rd_op    = 1'b1;
            uses_rs1 = 1'b1;
         end
         OP_BRANCH, OP_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_LOAD, OP_IMM: begin
            rd_op    = 1'b1;
            uses_rs1 = 1'b1;
         end
         OP_OP: begin
            rd_op    = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

   // x0 writes are architecturally discarded and must not occupy the scoreboard.
   assign writes_rd = rd_op & (rd != '0);

endmodule

// File: rtl/hazard_ctl.sv
// Decode-side hazard controller: RAW scoreboard stalls plus wrong-path flush after redirects.
module hazard_ctl
   import rv32_pkg::*;
#(
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned RF_BYPASS   = 0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   dec_instr,
   input  logic              dec_valid,
   input  logic              br_taken,
   output logic              stall,
   output logic              bubble,
   output logic              flush_dec,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam bit CHK_W = (RF_BYPASS == 0);

   logic             uses_rs1;
   logic             uses_rs2;
   logic             writes_rd;
   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic [REG_W-1:0] rd;

   sb_entry_t        sb_e_q, sb_a_q, sb_w_q, sb_e_d;
   hz_state_t        state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   logic             flush_act;
   logic             br_accept;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             hazard;
   logic             stall_int;
   logic             issue;

   hz_decode u_decode (
      .dec_instr (dec_instr),
      .uses_rs1  (uses_rs1),
      .uses_rs2  (uses_rs2),
      .writes_rd (writes_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd)
   );

   // Source matches against in-flight destinations; writeback only counts without RF write-through.
   assign rs1_hit = (rs1 != '0) &&
                    ((sb_e_q.valid && (sb_e_q.rd == rs1)) ||
                     (sb_a_q.valid && (sb_a_q.rd == rs1)) ||
                     (CHK_W && sb_w_q.valid && (sb_w_q.rd == rs1)));
   assign rs2_hit = (rs2 != '0) &&
                    ((sb_e_q.valid && (sb_e_q.rd == rs2)) ||
                     (sb_a_q.valid && (sb_a_q.rd == rs2)) ||
                     (CHK_W && sb_w_q.valid && (sb_w_q.rd == rs2)));

   assign hazard    = dec_valid & ((uses_rs1 & rs1_hit) | (uses_rs2 & rs2_hit));
   assign stall_int = hazard & ~flush_act;
   assign issue     = dec_valid & ~stall_int & ~flush_act & writes_rd;

   always_comb begin
      sb_e_d = SB_EMPTY;
      if (issue) begin
         sb_e_d.valid = 1'b1;
         sb_e_d.rd    = rd;
      end
   end

   // Redirect FSM: the br_taken cycle plus FLUSH_DEPTH-1 cycles in FLUSH kill decode.
   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      flush_act = 1'b0;
      br_accept = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (br_taken) begin
               flush_act = 1'b1;
               br_accept = 1'b1;
               if (FLUSH_DEPTH > 1) begin
                  state_d = ST_FLUSH;
                  fcnt_d  = FCNT_W'(FLUSH_DEPTH - 1);
               end
            end
         end
         ST_FLUSH: begin
            flush_act = 1'b1;
            if (fcnt_q <= FCNT_W'(1)) begin
               state_d = ST_RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d  = fcnt_q - FCNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         sb_e_q      <= SB_EMPTY;
         sb_a_q      <= SB_EMPTY;
         sb_w_q      <= SB_EMPTY;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         sb_w_q  <= sb_a_q;
         sb_a_q  <= sb_e_q;
         sb_e_q  <= sb_e_d;
         if (stall_int) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (br_accept) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   // Reset forces every output low, including the combinational controls.
   assign stall        = rst & stall_int;
   assign bubble       = rst & (stall_int | br_taken);
   assign flush_dec    = rst & flush_act;
   assign stall_cycles = rst ? stall_cnt_q : '0;
   assign flush_events = rst ? flush_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: two instances (RF_BYPASS 0 and 1) against a history-based reference model.
module tb_hazard_ctl;

   localparam int FD = 2;

   localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
   localparam logic [6:0] T_BR  = 7'h63, T_LD = 7'h03, T_ST = 7'h23, T_IMM = 7'h13, T_OP = 7'h33;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dec_instr;
   logic        dec_valid;
   logic        br_taken;

   logic        stall0, bubble0, flush0, stall1, bubble1, flush1;
   logic [15:0] sc0, fe0, sc1, fe1;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: last three issued destinations, newest first, per instance.
   bit m_v  [2][3];
   int m_rd [2][3];
   int m_fl [2];
   int m_sc [2];
   int m_fe [2];

   // Last sampled outputs per instance, for directed scenario checks.
   int o_s [2];
   int o_b [2];
   int o_f [2];
   int o_sc[2];
   int o_fe[2];

   always #5 clk = ~clk;

   hazard_ctl #(.FLUSH_DEPTH(FD), .RF_BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .dec_instr(dec_instr), .dec_valid(dec_valid), .br_taken(br_taken),
      .stall(stall0), .bubble(bubble0), .flush_dec(flush0), .stall_cycles(sc0), .flush_events(fe0)
   );

   hazard_ctl #(.FLUSH_DEPTH(FD), .RF_BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .dec_instr(dec_instr), .dec_valid(dec_valid), .br_taken(br_taken),
      .stall(stall1), .bubble(bubble1), .flush_dec(flush1), .stall_cycles(sc1), .flush_events(fe1)
   );

   task automatic check(input string tag, input int b, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, b, obs, exp);
      end
   endtask

   task automatic decode(input logic [31:0] ins, output bit u1, output bit u2, output bit wr,
                         output int r1, output int r2, output int rdd);
      logic [6:0] op;
      op  = ins[6:0];
      rdd = int'(ins[11:7]);
      r1  = int'(ins[19:15]);
      r2  = int'(ins[24:20]);
      u1  = op inside {T_JALR, T_BR, T_LD, T_ST, T_IMM, T_OP};
      u2  = op inside {T_BR, T_ST, T_OP};
      wr  = (op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_LD, T_IMM, T_OP}) && (rdd != 0);
   endtask

   function automatic bit in_flight(input int b, input int r);
      int depth;
      depth = (b == 1) ? 2 : 3;
      if (r == 0) return 1'b0;
      for (int i = 0; i < depth; i++)
         if (m_v[b][i] && m_rd[b][i] == r) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: sample/check at the falling edge, then advance the model past the rising edge.
   task automatic step(input bit chk);
      bit u1, u2, wr, hz, fl, st, bu, acc, iss;
      int r1, r2, rdd;
      bit n_v [2][3];
      int n_rd[2][3];
      int n_fl[2], n_sc[2], n_fe[2];
      int os, ob, of, osc, ofe;
      @(negedge clk);
      decode(dec_instr, u1, u2, wr, r1, r2, rdd);
      for (int b = 0; b < 2; b++) begin
         if (b == 0) begin
            os = int'(stall0); ob = int'(bubble0); of = int'(flush0); osc = int'(sc0); ofe = int'(fe0);
         end else begin
            os = int'(stall1); ob = int'(bubble1); of = int'(flush1); osc = int'(sc1); ofe = int'(fe1);
         end
         o_s[b] = os; o_b[b] = ob; o_f[b] = of; o_sc[b] = osc; o_fe[b] = ofe;
         hz  = dec_valid && ((u1 && in_flight(b, r1)) || (u2 && in_flight(b, r2)));
         fl  = br_taken || (m_fl[b] > 0);
         st  = hz && !fl;
         bu  = st || br_taken;
         acc = br_taken && (m_fl[b] == 0);
         iss = dec_valid && !st && !fl && wr;
         if (chk) begin
            check("stall",        b, os,  rst ? int'(st) : 0);
            check("bubble",       b, ob,  rst ? int'(bu) : 0);
            check("flush_dec",    b, of,  rst ? int'(fl) : 0);
            check("stall_cycles", b, osc, rst ? m_sc[b] : 0);
            check("flush_events", b, ofe, rst ? m_fe[b] : 0);
         end
         if (!rst) begin
            for (int i = 0; i < 3; i++) begin n_v[b][i] = 1'b0; n_rd[b][i] = 0; end
            n_fl[b] = 0; n_sc[b] = 0; n_fe[b] = 0;
         end else begin
            n_v[b][2] = m_v[b][1]; n_rd[b][2] = m_rd[b][1];
            n_v[b][1] = m_v[b][0]; n_rd[b][1] = m_rd[b][0];
            n_v[b][0] = iss;       n_rd[b][0] = iss ? rdd : 0;
            if (m_fl[b] > 0)  n_fl[b] = m_fl[b] - 1;
            else if (br_taken) n_fl[b] = FD - 1;
            else              n_fl[b] = 0;
            n_sc[b] = (st && m_sc[b] < 65535) ? m_sc[b] + 1 : m_sc[b];
            n_fe[b] = (acc && m_fe[b] < 65535) ? m_fe[b] + 1 : m_fe[b];
         end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 3; i++) begin m_v[b][i] = n_v[b][i]; m_rd[b][i] = n_rd[b][i]; end
         m_fl[b] = n_fl[b]; m_sc[b] = n_sc[b]; m_fe[b] = n_fe[b];
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] ins, input logic v, input logic br);
      rst = r; dec_instr = ins; dec_valid = v; br_taken = br;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1);
      step(1'b1);
   endtask

   initial begin
      int cnt [2];
      int fcnt[2];
      int bcnt[2];
      logic [31:0] ins;
      int pick;
      logic [6:0] ops[10];
      ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM, T_OP, 7'h7F};
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 3; i++) begin m_v[b][i] = 1'b0; m_rd[b][i] = 0; end
         m_fl[b] = 0; m_sc[b] = 0; m_fe[b] = 0;
      end

      // Reset state
      do_reset();
      for (int b = 0; b < 2; b++) begin
         check("rst_stall", b, o_s[b], 0);
         check("rst_flush", b, o_f[b], 0);
         check("rst_sc",    b, o_sc[b], 0);
      end

      // x0 destinations/sources and an unrelated store never stall
      drive(1'b1, 32'h00100013, 1'b1, 1'b0); step(1'b1);
      drive(1'b1, 32'h000003B3, 1'b1, 1'b0); step(1'b1);
      for (int b = 0; b < 2; b++) check("x0_nostall", b, o_s[b], 0);
      drive(1'b1, 32'h00532023, 1'b1, 1'b0); step(1'b1);
      for (int b = 0; b < 2; b++) check("sw_nostall", b, o_s[b], 0);

      // Back-to-back dependent pair
      do_reset();
      drive(1'b1, 32'h002082B3, 1'b1, 1'b0); step(1'b1);
      cnt[0] = 0; cnt[1] = 0;
      drive(1'b1, 32'h00328333, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b1);
         for (int b = 0; b < 2; b++) cnt[b] += o_s[b];
      end
      check("pair_stalls", 0, cnt[0], 3);
      check("pair_stalls", 1, cnt[1], 2);
      check("pair_sc", 0, o_sc[0], 3);
      check("pair_sc", 1, o_sc[1], 2);

      // Single redirect, then a second br_taken inside the flush window
      do_reset();
      fcnt[0] = 0; fcnt[1] = 0; bcnt[0] = 0; bcnt[1] = 0;
      drive(1'b1, 32'h00100013, 1'b1, 1'b1); step(1'b1);
      for (int b = 0; b < 2; b++) begin fcnt[b] += o_f[b]; bcnt[b] += o_b[b]; end
      drive(1'b1, 32'h00100013, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1);
         for (int b = 0; b < 2; b++) begin fcnt[b] += o_f[b]; bcnt[b] += o_b[b]; end
      end
      for (int b = 0; b < 2; b++) begin
         check("flush_len",  b, fcnt[b], 2);
         check("bubble_len", b, bcnt[b], 1);
         check("flush_ev1",  b, o_fe[b], 1);
      end
      fcnt[0] = 0; fcnt[1] = 0;
      drive(1'b1, 32'h00100013, 1'b1, 1'b1); step(1'b1);
      for (int b = 0; b < 2; b++) fcnt[b] += o_f[b];
      step(1'b1);
      for (int b = 0; b < 2; b++) fcnt[b] += o_f[b];
      drive(1'b1, 32'h00100013, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1);
         for (int b = 0; b < 2; b++) fcnt[b] += o_f[b];
      end
      for (int b = 0; b < 2; b++) begin
         check("flush_len2", b, fcnt[b], 2);
         check("flush_ev2",  b, o_fe[b], 2);
      end

      // Hazard coincident with br_taken: flush wins
      do_reset();
      drive(1'b1, 32'h002082B3, 1'b1, 1'b0); step(1'b1);
      drive(1'b1, 32'h00328333, 1'b1, 1'b1); step(1'b1);
      for (int b = 0; b < 2; b++) begin
         check("hzbr_stall",  b, o_s[b], 0);
         check("hzbr_flush",  b, o_f[b], 1);
         check("hzbr_bubble", b, o_b[b], 1);
      end
      drive(1'b1, 32'h00328333, 1'b1, 1'b0); step(1'b1);
      for (int b = 0; b < 2; b++) check("hzbr_sc", b, o_sc[b], 0);
      step(1'b1); step(1'b1); step(1'b1);

      // Reset during the second stall cycle
      do_reset();
      drive(1'b1, 32'h002082B3, 1'b1, 1'b0); step(1'b1);
      drive(1'b1, 32'h00328333, 1'b1, 1'b0); step(1'b1);
      drive(1'b0, 32'h00328333, 1'b1, 1'b0); step(1'b1);
      for (int b = 0; b < 2; b++) begin
         check("midrst_stall",  b, o_s[b], 0);
         check("midrst_bubble", b, o_b[b], 0);
         check("midrst_sc",     b, o_sc[b], 0);
         check("midrst_fe",     b, o_fe[b], 0);
      end
      drive(1'b1, 32'h00328333, 1'b1, 1'b0); step(1'b1);
      for (int b = 0; b < 2; b++) begin
         check("postrst_stall", b, o_s[b], 0);
         check("postrst_sc",    b, o_sc[b], 0);
      end

      // Randomized traffic over a small register set
      for (int k = 0; k < 3000; k++) begin
         ins = $urandom();
         pick = int'($urandom_range(9, 0));
         ins[6:0]   = ops[pick];
         ins[11:7]  = 5'($urandom_range(3, 0));
         ins[19:15] = 5'($urandom_range(3, 0));
         ins[24:20] = 5'($urandom_range(3, 0));
         drive(($urandom_range(199, 0) != 0), ins, ($urandom_range(3, 0) != 0),
               ($urandom_range(9, 0) == 0));
         step(1'b1);
      end

      // Long self-dependent stream drives stall_cycles into saturation
      do_reset();
      drive(1'b1, 32'h005282B3, 1'b1, 1'b0);
      for (int k = 0; k < 88000; k++) step(1'b0);
      step(1'b1);
      check("sat_sc", 0, o_sc[0], 65535);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
